led_step_seq: RTL and testbench

//   Timed 3-bit position sequencer feeding decoder38 ({a,b,c} -> one-hot out[7:0]) for the 8-LED board.

---
 rtl/led_step_seq.sv | 127 ++++++++++++
 tb/tb_led_step_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_step_seq.sv
// Timed 3-bit LED position sequencer (up / down / ping-pong / manual) feeding a 3-to-8 decoder.
// Latency: position and step_pulse update on the edge that sees the advance event (1 cycle); all outputs registered.
// Backpressure: none; en freezes the sequence and clears the prescaler, the outputs are always valid.
module led_step_seq #(
    parameter int CNT_MAX   = 25_000_000,
    parameter int CNT_WIDTH = 25
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       step_req,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       step_pulse
);

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_PING   = 2'b10;
    localparam logic [1:0] MODE_MANUAL = 2'b11;

    // Terminal prescaler value; CNT_MAX=1 makes this 0 so every enabled cycle ticks.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CNT_MAX - 1);

    // Ping-pong direction; only meaningful in MODE_PING, held at DIR_UP otherwise.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           pos_q, pos_d;
    dir_e                 dir_q, dir_d;
    logic                 step_pulse_q, step_pulse_d;

    logic run_prescaler;
    logic tick;
    logic manual_step;
    logic advance;

    // Prescaler: free-runs only while enabled in a timed mode, otherwise parked at zero.
    always_comb begin
        run_prescaler = en && (mode != MODE_MANUAL);
        tick          = run_prescaler && (cnt_q == CNT_LAST);
        cnt_d         = '0;
        if (run_prescaler && !tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Advance event: timer tick in the timed modes, or an enabled request in manual mode.
    always_comb begin
        manual_step = en && (mode == MODE_MANUAL) && step_req;
        advance     = tick || manual_step;
    end

    // Next position and ping-pong direction; dir snaps back to UP whenever ping-pong is not selected.
    always_comb begin
        pos_d = pos_q;
        dir_d = DIR_UP;
        unique case (mode)
            MODE_UP: begin
                if (advance) pos_d = pos_q + 3'd1;
            end
            MODE_DOWN: begin
                if (advance) pos_d = pos_q - 3'd1;
            end
            MODE_PING: begin
                dir_d = dir_q;
                if (advance) begin
                    if (dir_q == DIR_UP) begin
                        if (pos_q == 3'd7) begin
                            // Bounce off the top without repeating 7.
                            pos_d = 3'd6;
                            dir_d = DIR_DOWN;
                        end else begin
                            pos_d = pos_q + 3'd1;
                        end
                    end else begin
                        if (pos_q == 3'd0) begin
                            // Bounce off the bottom without repeating 0.
                            pos_d = 3'd1;
                            dir_d = DIR_UP;
                        end else begin
                            pos_d = pos_q - 3'd1;
                        end
                    end
                end
            end
            MODE_MANUAL: begin
                if (advance) pos_d = pos_q + 3'd1;
            end
            default: begin
                pos_d = pos_q;
            end
        endcase
    end

    // Step strobe marks the cycle in which a new position first appears on the outputs.
    always_comb begin
        step_pulse_d = advance;
    end

    // All sequencer state, including the direction FSM, in one registered block.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q        <= '0;
            pos_q        <= 3'd0;
            dir_q        <= DIR_UP;
            step_pulse_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    // Outputs come straight from flops: no combinational path from any input.
    assign a          = pos_q[2];
    assign b          = pos_q[1];
    assign c          = pos_q[0];
    assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_step_seq.sv
// Self-checking bench for led_step_seq with CNT_MAX=4.
// Directed scenarios, a table of manual-mode vectors, and randomized traffic against a reference model.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_led_step_seq;

    localparam int CNT_MAX   = 4;
    localparam int CNT_WIDTH = 3;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       step_req;
    logic       a, b, c;
    logic       step_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: prescaler count, position, ping-pong phase on a 14-step loop.
    int m_cnt;
    int m_pos;
    int m_phase;
    int m_pulse;

    led_step_seq #(
        .CNT_MAX   (CNT_MAX),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .Clk        (clk),
        .Reset      (rst),
        .en         (en),
        .mode       (mode),
        .step_req   (step_req),
        .a          (a),
        .b          (b),
        .c          (c),
        .step_pulse (step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       req;
        int         exp_pos;
        int         exp_pulse;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dut_pos();
        return int'({a, b, c});
    endfunction

    function automatic void model_reset();
        m_cnt   = 0;
        m_pos   = 0;
        m_phase = 0;
        m_pulse = 0;
    endfunction

    // One clock edge of the behavioural model.
    function automatic void model_edge(input logic e, input logic [1:0] m, input logic r);
        bit adv;
        adv = 0;
        if (e && m != 2'd3) begin
            if (m_cnt == CNT_MAX - 1) begin
                adv   = 1;
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else begin
            m_cnt = 0;
        end
        if (e && m == 2'd3 && r) adv = 1;
        if (adv) begin
            case (m)
                2'd0: m_pos = (m_pos + 1) % 8;
                2'd1: m_pos = (m_pos + 7) % 8;
                2'd2: begin
                    m_phase = (m_phase + 1) % 14;
                    m_pos   = (m_phase <= 7) ? m_phase : 14 - m_phase;
                end
                default: m_pos = (m_pos + 1) % 8;
            endcase
        end
        // Outside ping-pong the sweep restarts upward from the current position.
        if (m != 2'd2) m_phase = m_pos;
        m_pulse = adv ? 1 : 0;
    endfunction

    // Called at a falling edge: drive, clock, then compare on the next falling edge.
    task automatic cyc(input logic e, input logic [1:0] m, input logic r);
        en       = e;
        mode     = m;
        step_req = r;
        @(posedge clk);
        model_edge(e, m, r);
        @(negedge clk);
        chk("pos", dut_pos(), m_pos);
        chk("step_pulse", int'(step_pulse), m_pulse);
    endtask

    task automatic run(input int n, input logic e, input logic [1:0] m);
        for (int i = 0; i < n; i++) cyc(e, m, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        int wait_cnt;
        bit seen;
        logic       r_en;
        logic [1:0] r_mode;
        logic       r_req;

        rst      = 1'b1;
        en       = 1'b0;
        mode     = 2'd0;
        step_req = 1'b0;
        model_reset();

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("reset_pos", dut_pos(), 0);
        chk("reset_pulse", int'(step_pulse), 0);
        rst = 1'b0;

        // 1: up counting, one step every 4 clocks; 36 clocks gives 9 steps.
        run(36, 1'b1, 2'd0);
        chk("up_after_36", dut_pos(), 1);
        chk("up_pulse_on_step", int'(step_pulse), 1);
        run(28, 1'b1, 2'd0);
        chk("up_back_to_0", dut_pos(), 0);

        // 2: down from 0 wraps to 7 then 6.
        run(4, 1'b1, 2'd1);
        chk("down_wrap_7", dut_pos(), 7);
        run(4, 1'b1, 2'd1);
        chk("down_6", dut_pos(), 6);
        run(4, 1'b1, 2'd1);
        chk("down_5", dut_pos(), 5);

        // 3: ping-pong from 5: 6,7,6,5,4,3,2,1,0,1.
        run(8, 1'b1, 2'd2);
        chk("pp_top_7", dut_pos(), 7);
        run(4, 1'b1, 2'd2);
        chk("pp_bounce_6", dut_pos(), 6);
        run(24, 1'b1, 2'd2);
        chk("pp_bottom_0", dut_pos(), 0);
        run(4, 1'b1, 2'd2);
        chk("pp_bounce_1", dut_pos(), 1);

        // 4: freeze mid-count, then first step exactly 4 clocks after re-enable.
        run(2, 1'b1, 2'd0);
        run(10, 1'b0, 2'd0);
        chk("freeze_pos", dut_pos(), 1);
        wait_cnt = 0;
        seen     = 0;
        while (!seen && wait_cnt < 20) begin
            cyc(1'b1, 2'd0, 1'b0);
            wait_cnt++;
            if (step_pulse) seen = 1;
        end
        chk("reenable_latency", wait_cnt, 4);
        chk("reenable_pos", dut_pos(), 2);

        // 5: manual mode vectors from reset.
        do_reset();
        vecs[0]  = '{1'b1, 2'd3, 1'b0, 0, 0};
        vecs[1]  = '{1'b1, 2'd3, 1'b0, 0, 0};
        vecs[2]  = '{1'b1, 2'd3, 1'b0, 0, 0};
        vecs[3]  = '{1'b1, 2'd3, 1'b1, 1, 1};
        vecs[4]  = '{1'b1, 2'd3, 1'b0, 1, 0};
        vecs[5]  = '{1'b0, 2'd3, 1'b1, 1, 0};
        vecs[6]  = '{1'b1, 2'd3, 1'b0, 1, 0};
        vecs[7]  = '{1'b1, 2'd3, 1'b0, 1, 0};
        vecs[8]  = '{1'b1, 2'd3, 1'b0, 1, 0};
        vecs[9]  = '{1'b1, 2'd3, 1'b1, 2, 1};
        vecs[10] = '{1'b1, 2'd3, 1'b1, 3, 1};
        vecs[11] = '{1'b1, 2'd3, 1'b0, 3, 0};
        vecs[12] = '{1'b1, 2'd0, 1'b1, 3, 0};
        vecs[13] = '{1'b1, 2'd3, 1'b0, 3, 0};
        for (int i = 0; i < 14; i++) begin
            cyc(vecs[i].en, vecs[i].mode, vecs[i].req);
            chk($sformatf("vec%0d_pos", i), dut_pos(), vecs[i].exp_pos);
            chk($sformatf("vec%0d_pulse", i), int'(step_pulse), vecs[i].exp_pulse);
        end

        // 6: async reset with pos=6 heading down, then ping-pong restarts upward.
        do_reset();
        run(32, 1'b1, 2'd2);
        chk("pre_reset_pos", dut_pos(), 6);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_pos", dut_pos(), 0);
        chk("async_reset_pulse", int'(step_pulse), 0);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        run(8, 1'b1, 2'd2);
        chk("post_reset_up", dut_pos(), 2);

        // Randomized traffic against the model.
        r_mode = 2'd0;
        for (int i = 0; i < 600; i++) begin
            r_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) r_mode = 2'($urandom_range(0, 3));
            r_req = ($urandom_range(0, 3) == 0);
            cyc(r_en, r_mode, r_req);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time guard so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
